// File: rtl/cdr_scan_controller.sv
// Scan-chain sequencer for the CDR: serially loads a test pattern, optionally
// runs a capture window, and unloads the previous chain contents into result.
module cdr_scan_controller #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 CoreIN_RESET,
  input  logic                 start,
  input  logic                 shift_only,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 chain_so,
  output logic                 chain_si,
  output logic                 se,
  output logic                 ready,
  output logic [CHAIN_LEN-1:0] result,
  output logic                 result_valid
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam int CAP_W = $clog2(CAPTURE_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAPTURE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] patSh_q, patSh_d;
  logic [CHAIN_LEN-1:0] unl_q, unl_d;
  logic [CHAIN_LEN-1:0] result_q, result_d;
  logic [CNT_W-1:0]     bitCnt_q, bitCnt_d;
  logic [CAP_W-1:0]     capCnt_q, capCnt_d;
  logic                 shiftOnly_q, shiftOnly_d;
  logic                 resultValid_q, resultValid_d;

  always_ff @(posedge CLK) begin
    if (!CoreIN_RESET) begin
      state_q       <= IDLE;
      patSh_q       <= '0;
      unl_q         <= '0;
      result_q      <= '0;
      bitCnt_q      <= '0;
      capCnt_q      <= '0;
      shiftOnly_q   <= 1'b0;
      resultValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      patSh_q       <= patSh_d;
      unl_q         <= unl_d;
      result_q      <= result_d;
      bitCnt_q      <= bitCnt_d;
      capCnt_q      <= capCnt_d;
      shiftOnly_q   <= shiftOnly_d;
      resultValid_q <= resultValid_d;
    end
  end

  // Abort beats both a fresh start and shift/capture completion; DONE ignores it.
  always_comb begin
    state_d       = state_q;
    patSh_d       = patSh_q;
    unl_d         = unl_q;
    result_d      = result_q;
    bitCnt_d      = bitCnt_q;
    capCnt_d      = capCnt_q;
    shiftOnly_d   = shiftOnly_q;
    resultValid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          patSh_d     = pattern;
          shiftOnly_d = shift_only;
          bitCnt_d    = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          patSh_d = {patSh_q[CHAIN_LEN-2:0], 1'b0};
          unl_d   = {unl_q[CHAIN_LEN-2:0], chain_so};
          if (bitCnt_q == BIT_LAST) begin
            capCnt_d = '0;
            state_d  = shiftOnly_q ? DONE : CAPTURE;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (capCnt_q == CAP_LAST) begin
          state_d = DONE;
        end else begin
          capCnt_d = capCnt_q + CAP_W'(1);
        end
      end
      DONE: begin
        result_d      = unl_q;
        resultValid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign se           = (state_q == SHIFT);
  assign ready        = (state_q == IDLE);
  assign chain_si     = (state_q == SHIFT) & patSh_q[CHAIN_LEN-1];
  assign result       = result_q;
  assign result_valid = resultValid_q;

endmodule
